// File: rtl/uart_rx_baud_if.sv
// UART receive bundle: serial line and rate select toward the receiver, byte and status back.
// Pure wiring, no added latency.
// No backpressure: results are single-cycle strobes that the consumer must capture.
interface uart_rx_baud_if;
    logic       rx;
    logic [1:0] baud_select;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx, baud_select,
        input  rx_data, rx_valid, rx_busy, frame_err, parity_err
    );

    modport slave (
        input  rx, baud_select,
        output rx_data, rx_valid, rx_busy, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_baud.sv
// 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined), rate from baud_select.
// Start seen 3 clocks after the line falls; rx_valid/frame_err one clock after the mid-stop tick.
// No backpressure: each byte is offered for exactly one cycle and never held for a consumer.
module uart_rx_baud #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OS_DIV_0 = 1302,
    parameter int OS_DIV_1 = 651,
    parameter int OS_DIV_2 = 326,
    parameter int OS_DIV_3 = 163
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_baud_if.slave  bus
);

    // Elaboration-time sanity check; the divisors must allow a tick at all.
    if (CLK_FREQ <= 0 || OS_DIV_0 < 1 || OS_DIV_1 < 1 || OS_DIV_2 < 1 || OS_DIV_3 < 1) begin : g_param_check
        $error("uart_rx_baud: CLK_FREQ and all OS_DIV_x must be positive");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
`ifdef UART_RX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta, rxs;
    logic [15:0] sel_div;
    logic [15:0] div_q, div_d;
    logic [15:0] baud_cnt_q;
    logic        tick;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        pflag_q, pflag_d;
    logic        perr_q, perr_d;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rxs     <= rx_meta;
        end
    end

    // Divisor for the currently requested rate; only sampled at start detection.
    always_comb begin
        case (bus.baud_select)
            2'b00:   sel_div = 16'(OS_DIV_0);
            2'b01:   sel_div = 16'(OS_DIV_1);
            2'b10:   sel_div = 16'(OS_DIV_2);
            default: sel_div = 16'(OS_DIV_3);
        endcase
    end

    // Oversample tick generator; parked at zero while no frame is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            baud_cnt_q <= '0;
        end else if (state_q == ST_IDLE || state_q == ST_BREAK || tick) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
        end
    end

    assign tick = (state_q != ST_IDLE) && (baud_cnt_q == div_q - 16'd1);

    // State and datapath registers; every output is registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pflag_q    <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pflag_q    <= pflag_d;
            perr_q     <= perr_d;
`endif
        end
    end

    // Next-state and next-datapath logic; strobes default low so they last one cycle.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        pflag_d    = pflag_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rxs) begin
                    state_d = ST_START;
                    div_d   = sel_div;
                end
            end
            ST_START: begin
                // Eighth tick is mid start bit; a high line here was only a glitch.
                if (tick && tick_cnt_q == 4'd7) begin
                    tick_cnt_d = '0;
                    state_d    = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                // Even parity: the parity bit must equal the XOR of the data bits.
                if (tick && tick_cnt_q == 4'd15) begin
                    pflag_d = rxs ^ (^shift_q);
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = pflag_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off start detection until the line has been released.
                tick_cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_baud.sv
// Randomised frame stimulus against a byte-level scoreboard for uart_rx_baud.
// Expectations are queued when a frame starts and consumed when the receiver strobes.
// Runs at baud_select=11 with a 4-clock oversample tick (64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_baud;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_baud_if bus();

    uart_rx_baud #(.OS_DIV_3(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    exp_t sb_q[$];

    // Counters and model state owned by the monitor process only.
    int         checks = 0;
    int         errors = 0;
    int         req_seen = 0;
    int         busy_run = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_busy = 1'b0;

    // Requests from the stimulus process (written there only).
    int         req_cnt = 0;
    int         req_kind = 0;
    logic       req_val = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes scoreboard entries on every receiver strobe.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rx_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h expected no output", bus.rx_data);
            end else begin
                e = sb_q.pop_front();
                chk("valid_not_ferr_frame", {31'd0, e.is_ferr}, 32'd0);
                chk("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
                chk("parity_err_at_valid", {31'd0, bus.parity_err}, {31'd0, e.perr});
                chk("frame_err_at_valid", {31'd0, bus.frame_err}, 32'd0);
                chk("busy_low_at_valid", {31'd0, bus.rx_busy}, 32'd0);
                chk("busy_high_before_valid", {31'd0, prev_busy}, 32'd1);
                chk("valid_width", {31'd0, prev_valid}, 32'd0);
                last_good = e.data;
            end
        end
        if (bus.frame_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_err: got 1 expected no output");
            end else begin
                e = sb_q.pop_front();
                chk("ferr_on_bad_stop_frame", {31'd0, e.is_ferr}, 32'd1);
                chk("rx_data_held_on_ferr", {24'd0, bus.rx_data}, {24'd0, last_good});
                chk("ferr_width", {31'd0, prev_ferr}, 32'd0);
            end
        end
        if (bus.parity_err === 1'b1 && bus.rx_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL stray_parity_err: got 1 expected 0 without rx_valid");
        end
        busy_run = (bus.rx_busy === 1'b1) ? busy_run + 1 : 0;
        if (busy_run == 2000) begin
            checks++;
            errors++;
            $display("FAIL busy_stuck: got busy for 2000 clocks expected return to idle");
        end
        if (req_cnt != req_seen) begin
            req_seen = req_cnt;
            case (req_kind)
                0: begin
                    chk("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
                    chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
                    chk("reset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
                    chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
                    chk("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
                    last_good = 8'h00;
                end
                1: chk("rx_busy_level", {31'd0, bus.rx_busy}, {31'd0, req_val});
                default: begin
                    chk("scoreboard_drained", sb_q.size(), 32'd0);
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
            endcase
        end
        prev_valid = bus.rx_valid;
        prev_ferr  = bus.frame_err;
        prev_busy  = bus.rx_busy;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic request(input int kind, input logic val);
        req_kind = kind;
        req_val  = val;
        req_cnt++;
        wait_clks(2);
    endtask

    // Drives one frame and queues what a correct receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input bit switch_sel, input int bp);
        exp_t e;
        e.is_ferr = !stop_ok;
        e.data    = d;
`ifdef UART_RX_PARITY_EN
        e.perr    = stop_ok && !par_ok;
`else
        e.perr    = 1'b0 & par_ok;
`endif
        sb_q.push_back(e);
        bus.rx = 1'b0;
        wait_clks(bp);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_clks(bp);
            if (switch_sel && i == 3) bus.baud_select = 2'b00;
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = (^d) ^ !par_ok;
        wait_clks(bp);
`endif
        if (stop_ok) begin
            bus.rx = 1'b1;
            wait_clks(bp);
        end else begin
            bus.rx = 1'b0;
            wait_clks(2 * bp);
            bus.rx = 1'b1;
            wait_clks(bp);
        end
        bus.baud_select = 2'b11;
    endtask

    initial begin
        logic [7:0] d;
        bus.rx = 1'b1;
        bus.baud_select = 2'b11;
        reset = 1'b0;
        wait_clks(5);
        reset = 1'b1;
        request(0, 1'b0);
        wait_clks(2 * BIT_CLKS);

        send_frame(8'hA5, 1, 1, 0, BIT_CLKS);
        wait_clks(BIT_CLKS);

        // Short low glitch: receiver must start, reject at mid start bit, and go idle.
        bus.rx = 1'b0;
        wait_clks(8);
        request(1, 1'b1);
        wait_clks(6);
        bus.rx = 1'b1;
        wait_clks(32);
        request(1, 1'b0);
        wait_clks(BIT_CLKS);

        // Stop bit held low for two bit times, then a good frame.
        send_frame(8'h3C, 0, 1, 0, BIT_CLKS);
        wait_clks(BIT_CLKS);
        send_frame(8'h5A, 1, 1, 0, BIT_CLKS);
        wait_clks(BIT_CLKS);

        // Reset pulse during data bit 3 aborts the frame.
        d = 8'h96;
        bus.rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            bus.rx = d[i];
            wait_clks(BIT_CLKS);
        end
        bus.rx = d[3];
        wait_clks(BIT_CLKS / 2);
        reset = 1'b0;
        bus.rx = 1'b1;
        wait_clks(1);
        reset = 1'b1;
        request(0, 1'b0);
        wait_clks(12 * BIT_CLKS);
        send_frame(8'h5A, 1, 1, 0, BIT_CLKS);
        wait_clks(BIT_CLKS);

        // Rate select changes mid-frame; the latched rate must be kept.
        send_frame(8'hC3, 1, 1, 1, BIT_CLKS);
        wait_clks(BIT_CLKS);

        // Back-to-back frames with one stop bit and slight rate mismatch.
        for (int n = 0; n < 6; n++) begin
            send_frame(8'($urandom), 1, ($urandom_range(0, 3) != 0),
                       0, BIT_CLKS - 1 + int'($urandom_range(0, 2)));
        end
        wait_clks(BIT_CLKS);

        // Random frames, occasional bad stop bit, random idle gaps.
        for (int n = 0; n < 8; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                       0, BIT_CLKS - 1 + int'($urandom_range(0, 2)));
            wait_clks(int'($urandom_range(0, 3)) * BIT_CLKS);
        end

`ifdef UART_RX_PARITY_EN
        wait_clks(BIT_CLKS);
        send_frame(8'h07, 1, 1, 0, BIT_CLKS);
        wait_clks(BIT_CLKS);
        send_frame(8'h07, 1, 0, 0, BIT_CLKS);
`endif
        wait_clks(4 * BIT_CLKS);
        request(2, 1'b0);
    end

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL timeout: got no completion expected finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_baud.md
# uart_rx_baud

UART receiver paired with the board's existing selectable-baud UART transmitter path. It recovers 8N1 frames from the serial line using 16x oversampling, using the same 2-bit `baud_select` encoding as the transmitter. Each received byte is presented with a one-cycle valid strobe so it can feed the seven-segment display path or a loopback checker.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz. Documentation only; the divisors below are the real configuration.
- `OS_DIV_0`, 1302: clocks per oversample tick for `baud_select`=00 (2400 baud).
- `OS_DIV_1`, 651: clocks per tick for 01 (4800 baud).
- `OS_DIV_2`, 326: clocks per tick for 10 (9600 baud).
- `OS_DIV_3`, 163: clocks per tick for 11 (19200 baud).

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `baud_select`  in  2  rate select; latched at start-bit detection.
- `rx_data`  out  8  last good byte; holds its value between frames.
- `rx_valid`  out  1  one-cycle strobe when `rx_data` updates.
- `rx_busy`  out  1  high from start detection until return to IDLE.
- `frame_err`  out  1  one-cycle strobe when the stop bit samples 0.
- `parity_err`  out  1  one-cycle strobe; present only when parity is enabled (see Configuration).

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- Tick generator:
  - Counter runs 0..DIV-1 and asserts `tick` when count = DIV-1.
  - The counter is held at 0 in IDLE and starts counting on the cycle after start detection.
  - DIV is taken from `baud_select` latched on entry to START. A change of `baud_select` mid-frame has no effect.
- Per-state counters: tick counter 0..15; bit counter 0..7.
- FSM states:
  - IDLE: `rxs`=0 → START; latch the divisor.
  - START: at tick 7 (mid-bit), if `rxs`=1 the start was false → IDLE with no outputs. Otherwise reset the tick counter and go to DATA.
  - DATA: sample at each 16th tick (mid-bit) and shift LSB first. After bit 7 → STOP, or PARITY when enabled.
  - PARITY: sample mid-bit and compare to even parity of the byte → STOP.
  - STOP: sample mid-bit.
    - `rxs`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - `rxs`=0: pulse `frame_err`, leave `rx_data` unchanged, no `rx_valid`, go to BREAK.
  - BREAK: wait for `rxs`=1 → IDLE. No start detection happens while the line is held low.
- `rx_busy` = (state != IDLE).

## Timing
- Reset values:
  - `rx_data`=8'h00; `rx_valid`, `frame_err`, `parity_err`, `rx_busy` = 0.
  - State IDLE; all counters 0.
- Reset asserted mid-frame takes effect on the next clock edge and discards the partial byte.
- Input to detection: 2 clocks of synchronizer plus 1 clock for the IDLE→START transition.
- `rx_valid` and `frame_err` are registered and assert on the cycle after the mid-stop `tick`. Each is exactly 1 cycle wide.
- IDLE can be re-entered and a new start detected on the very next cycle, so back-to-back frames with a single stop bit are supported.
- Mid-bit sampling point: start + 8 ticks for start, then every 16 ticks. The receiver tolerates about ±4% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame becomes 8E1 and the PARITY state is included.
  - `parity_err` pulses together with `rx_valid` on a parity mismatch. `rx_data` is still updated.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1 and the PARITY state is absent.
  - `parity_err` is tied to 0.

## Test plan
Benches override `OS_DIV_3`=4 (64 clocks per bit) and use `baud_select`=11 unless noted.
- Send 0xA5 as an 8N1 frame → one `rx_valid` pulse with `rx_data`=0xA5; `frame_err`=0; `rx_busy` falls the cycle `rx_valid` rises.
- Drive a low glitch on `rx` for 16 clocks (4 ticks) → no `rx_valid` and no `frame_err`; `rx_busy` returns to 0 within 10 ticks.
- After 0xA5, send 0x3C with the stop bit held at 0 for 2 bit times, then release → `frame_err` pulses once and `rx_data` stays 0xA5. A following 0x5A frame is received correctly.
- Assert `reset`=0 for one clock during data bit 3 of a frame → all outputs are at reset values on the next edge. A subsequent 0x5A frame is received correctly.
- Start a 0xC3 frame at `baud_select`=11, then switch to 00 mid-frame → 0xC3 is received at the latched rate with no error.
- With `UART_RX_PARITY_EN`:
  - Send 0x07 with parity bit 1 → `rx_valid` with `parity_err`=0.
  - Send 0x07 with parity bit 0 → `rx_valid` with `parity_err`=1 and `rx_data`=0x07.
